// File: rtl/bc_operand_sequencer.sv
// Lane-0 broadcast consumer: splits popped 64-bit words into fp32 scalars, replays the vector reps times, then frees the buffer half.
// Latency: config -> first pop 1 cycle, pop -> scalar 1 cycle, final handshake -> invalidate 1 cycle; 1 scalar/cycle steady state.
// Backpressure: scalar_ready_i low holds scalar_o stable and withholds pops; bc_ready_o never looks at bc_valid_i.
module bc_operand_sequencer #(
    parameter int MaxBlen = 32,
    parameter int MaxReps = 256,
    localparam int BlenWidth = $clog2(MaxBlen + 1),
    localparam int RepsWidth = $clog2(MaxReps + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [BlenWidth-1:0] cfg_blen_i,
    input  logic [RepsWidth-1:0] cfg_reps_i,
    input  logic                 abort_i,
    input  logic [63:0]          bc_data_i,
    input  logic                 bc_valid_i,
    output logic                 bc_ready_o,
    output logic                 bc_invalidate_o,
    output logic [31:0]          scalar_o,
    output logic                 scalar_valid_o,
    input  logic                 scalar_ready_i,
    output logic                 scalar_last_o,
    output logic                 scalar_final_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Run  = 2'd1,
        Inv  = 2'd2
    } state_e;

    state_e               state_q;
    logic [63:0]          hold_dat;
    logic                 hold_vld;
    logic                 hold_half;
    logic [BlenWidth-1:0] elem_cnt;
    logic [RepsWidth-1:0] pass_cnt;
    logic [BlenWidth-1:0] blen_m1;
    logic [RepsWidth-1:0] reps_m1;

    logic run;
    logic elem_last;
    logic pass_last;
    logic scalar_hs;
    logic word_done;
    logic final_hs;
    logic pop;

    assign run       = (state_q == Run);
    assign elem_last = (elem_cnt == blen_m1);
    assign pass_last = (pass_cnt == reps_m1);
    // abort wins over a same-cycle handshake, so it is excluded here
    assign scalar_hs = scalar_valid_o && scalar_ready_i && !abort_i;
    // odd blen: the lo half of the final word is the last element taken from it
    assign word_done = hold_half || elem_last;
    assign final_hs  = scalar_hs && elem_last && pass_last;

    assign bc_ready_o = run && !abort_i && (!hold_vld || (scalar_hs && word_done && !final_hs));
    assign pop        = bc_ready_o && bc_valid_i;

    assign cfg_ready_o     = (state_q == Idle);
    assign busy_o          = (state_q != Idle);
    assign bc_invalidate_o = (state_q == Inv);
    assign scalar_valid_o  = run && hold_vld;
    assign scalar_o        = hold_half ? hold_dat[63:32] : hold_dat[31:0];
    assign scalar_last_o   = scalar_valid_o && elem_last;
    assign scalar_final_o  = scalar_last_o && pass_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            hold_dat  <= '0;
            hold_vld  <= 1'b0;
            hold_half <= 1'b0;
            elem_cnt  <= '0;
            pass_cnt  <= '0;
            blen_m1   <= '0;
            reps_m1   <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (cfg_valid_i) begin
                        blen_m1   <= cfg_blen_i - BlenWidth'(1);
                        reps_m1   <= cfg_reps_i - RepsWidth'(1);
                        elem_cnt  <= '0;
                        pass_cnt  <= '0;
                        hold_vld  <= 1'b0;
                        hold_half <= 1'b0;
                        state_q   <= (cfg_blen_i == '0 || cfg_reps_i == '0) ? Inv : Run;
                    end
                end
                Run: begin
                    if (abort_i) begin
                        hold_vld <= 1'b0;
                        state_q  <= Inv;
                    end else begin
                        if (scalar_hs) begin
                            if (elem_last) begin
                                elem_cnt <= '0;
                                if (!pass_last) pass_cnt <= pass_cnt + RepsWidth'(1);
                            end else begin
                                elem_cnt <= elem_cnt + BlenWidth'(1);
                            end
                        end
                        // a refill always restarts at the lo half, which also covers the pass wrap
                        if (pop) begin
                            hold_dat  <= bc_data_i;
                            hold_vld  <= 1'b1;
                            hold_half <= 1'b0;
                        end else if (scalar_hs) begin
                            if (word_done) begin
                                hold_vld  <= 1'b0;
                                hold_half <= 1'b0;
                            end else begin
                                hold_half <= 1'b1;
                            end
                        end
                        if (final_hs) state_q <= Inv;
                    end
                end
                Inv:     state_q <= Idle;
                default: state_q <= Idle;
            endcase
        end
    end

    blen_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cfg_valid_i && cfg_ready_o) |-> (int'(cfg_blen_i) <= MaxBlen));

endmodule

// File: tb/tb_bc_operand_sequencer.sv
// Bench for bc_operand_sequencer: replaying buffer model plus expected-scalar queue built from the vector layout.
module tb_bc_operand_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [5:0]  cfg_blen_i;
    logic [8:0]  cfg_reps_i;
    logic        abort_i;
    logic [63:0] bc_data_i;
    logic        bc_valid_i;
    logic        bc_ready_o;
    logic        bc_invalidate_o;
    logic [31:0] scalar_o;
    logic        scalar_valid_o;
    logic        scalar_ready_i;
    logic        scalar_last_o;
    logic        scalar_final_o;
    logic        busy_o;

    bc_operand_sequencer #(.MaxBlen(32), .MaxReps(256)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_blen_i(cfg_blen_i), .cfg_reps_i(cfg_reps_i),
        .abort_i(abort_i),
        .bc_data_i(bc_data_i), .bc_valid_i(bc_valid_i), .bc_ready_o(bc_ready_o),
        .bc_invalidate_o(bc_invalidate_o),
        .scalar_o(scalar_o), .scalar_valid_o(scalar_valid_o), .scalar_ready_i(scalar_ready_i),
        .scalar_last_o(scalar_last_o), .scalar_final_o(scalar_final_o),
        .busy_o(busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] v;
        logic        l;
        logic        f;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] words [16];
    int          nw;
    int          bidx;
    bit          pop_pend;
    int          pops;
    int          invs;
    bit          stall_prev;
    logic [31:0] prev_sc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Element e of the vector lives in word e/2, lo half for even e; the vector replays every pass.
    task automatic build_model(input int blen, input int reps);
        exp_q.delete();
        for (int p = 0; p < reps; p++) begin
            for (int e = 0; e < blen; e++) begin
                exp_t        x;
                logic [63:0] w;
                w   = words[e / 2];
                x.v = (e % 2 == 1) ? w[63:32] : w[31:0];
                x.l = (e == blen - 1);
                x.f = (e == blen - 1) && (p == reps - 1);
                exp_q.push_back(x);
            end
        end
    endtask

    // advance the replaying buffer after the edge a pop happened on
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (pop_pend) bidx = (bidx + 1) % nw;
        pop_pend  = 1'b0;
        bc_data_i = words[bidx];
    endtask

    // per-cycle compare against the model queue, sampled on the falling edge
    task automatic observe();
        @(negedge clk_i);
        pop_pend = 1'b0;
        if (!rst_ni) begin
            stall_prev = 1'b0;
            return;
        end
        if (bc_ready_o && bc_valid_i) begin
            pop_pend = 1'b1;
            pops++;
        end
        if (bc_invalidate_o) invs++;
        if (scalar_valid_o) begin
            if (stall_prev) chk("stable_during_stall", scalar_o, prev_sc);
            if (exp_q.size() == 0) begin
                chk("spurious_scalar_valid", 1, 0);
            end else begin
                chk("scalar", scalar_o, exp_q[0].v);
                chk("scalar_last", scalar_last_o, exp_q[0].l);
                chk("scalar_final", scalar_final_o, exp_q[0].f);
                if (scalar_ready_i && !abort_i) void'(exp_q.pop_front());
            end
        end
        stall_prev = scalar_valid_o && !scalar_ready_i && !abort_i;
        prev_sc    = scalar_o;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_bc_ready"}, bc_ready_o, 0);
        chk({tag, "_invalidate"}, bc_invalidate_o, 0);
        chk({tag, "_scalar_valid"}, scalar_valid_o, 0);
        chk({tag, "_last"}, scalar_last_o, 0);
        chk({tag, "_final"}, scalar_final_o, 0);
    endtask

    task automatic run_job(input int blen, input int reps, input int rdy_pct,
                           input int abort_at, input int rst_at, input int exp_pops);
        int hs, first_v, fin_k, inv_k, abort_k;
        bit live;
        live = (blen > 0) && (reps > 0);
        nw   = live ? (blen + 1) / 2 : 1;
        pops = 0; invs = 0; bidx = 0; pop_pend = 1'b0; stall_prev = 1'b0;
        if (live) build_model(blen, reps); else exp_q.delete();
        tick();
        cfg_valid_i    = 1'b1;
        cfg_blen_i     = 6'(blen);
        cfg_reps_i     = 9'(reps);
        scalar_ready_i = 1'b1;
        abort_i        = 1'b0;
        bc_valid_i     = 1'b1;
        #1;
        chk("cfg_ready_idle", cfg_ready_o, 1);
        observe();
        tick();
        cfg_valid_i = 1'b0;
        hs = 0; first_v = -1; fin_k = -1; inv_k = -1; abort_k = -1;
        for (int k = 1; k < 3000 && inv_k < 0; k++) begin
            scalar_ready_i = ($urandom_range(0, 99) < rdy_pct);
            if (rdy_pct < 100) bc_valid_i = ($urandom_range(0, 3) != 0);
            abort_i = 1'b0;
            #1;
            if (k == 1) chk("bc_ready_after_cfg", bc_ready_o, live);
            if (scalar_valid_o && hs == rst_at) begin
                #1 rst_ni = 1'b0;
                #1;
                chk_reset_outs("async_reset");
                observe();
                tick();
                tick();
                rst_ni = 1'b1;
                exp_q.delete();
                bidx = 0;
                return;
            end
            if (scalar_valid_o && hs == abort_at) begin
                abort_i        = 1'b1;
                scalar_ready_i = 1'b1;
                abort_k        = k;
            end
            if (scalar_valid_o && first_v < 0) first_v = k;
            if (bc_invalidate_o) inv_k = k;
            observe();
            if (scalar_valid_o && scalar_ready_i && !abort_i) begin
                hs++;
                if (scalar_final_o) fin_k = k;
            end
            tick();
        end
        abort_i        = 1'b0;
        scalar_ready_i = 1'b1;
        bc_valid_i     = 1'b1;
        #1;
        chk("invalidate_seen", inv_k >= 0, 1);
        chk("cfg_ready_after_inv", cfg_ready_o, 1);
        chk("invalidate_single_cycle", bc_invalidate_o, 0);
        observe();
        if (abort_at >= 0) begin
            chk("inv_after_abort", inv_k, abort_k + 1);
            chk("abort_hs_not_counted", exp_q.size(), blen * reps - abort_at);
            exp_q.delete();
        end else if (live) begin
            chk("inv_after_final", inv_k, fin_k + 1);
            chk("scalars_delivered", hs, blen * reps);
            chk("model_drained", exp_q.size(), 0);
            if (rdy_pct == 100) begin
                chk("first_valid_cycle", first_v, 2);
                chk("no_bubble", fin_k - first_v, blen * reps - 1);
            end
        end else begin
            chk("zero_job_inv_t1", inv_k, 1);
            chk("zero_job_no_valid", first_v, -1);
        end
        chk("pop_count", pops, exp_pops);
        chk("invalidate_count", invs, 1);
    endtask

    initial begin
        rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_blen_i = '0; cfg_reps_i = '0;
        abort_i = 1'b0; bc_data_i = '0; bc_valid_i = 1'b0; scalar_ready_i = 1'b0;
        pop_pend = 1'b0; bidx = 0; nw = 1;
        for (int i = 0; i < 16; i++) words[i] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outs("reset");
        chk("reset_scalar_o", scalar_o, 0);
        rst_ni = 1'b1;

        // basic 4-element single pass
        words[0] = 64'h3F800000_00000000;
        words[1] = 64'h40400000_40000000;
        build_model(4, 1);
        chk("model_e1", exp_q[1].v, 32'h3F800000);
        chk("model_e3", exp_q[3].v, 32'h40400000);
        chk("model_e3_final", exp_q[3].f, 1);
        run_job(4, 1, 100, -1, -1, 2);

        // odd length, two passes over a replayed buffer
        words[0] = 64'hBF800000_3F800000;
        words[1] = 64'hDEADBEEF_40000000;
        build_model(3, 2);
        chk("model_odd_e2", exp_q[2].v, 32'h40000000);
        chk("model_odd_e2_last_not_final", {exp_q[2].l, exp_q[2].f}, 2'b10);
        chk("model_odd_e5_final", exp_q[5].f, 1);
        run_job(3, 2, 100, -1, -1, 4);

        // full-length vector with random stalls on both sides
        for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom};
        run_job(32, 5, 50, -1, -1, 80);

        // abort coinciding with the 5th scalar handshake
        for (int i = 0; i < 4; i++) words[i] = {32'h41000000 + 32'(2 * i + 1), 32'h41000000 + 32'(2 * i)};
        run_job(8, 2, 100, 4, -1, 3);

        // degenerate jobs
        run_job(0, 3, 100, -1, -1, 0);
        run_job(4, 0, 100, -1, -1, 0);

        // asynchronous reset mid-pass, then a fresh job from element 0
        run_job(8, 2, 100, -1, 3, 0);
        words[0] = 64'h3F800000_00000000;
        words[1] = 64'h40400000_40000000;
        run_job(4, 1, 100, -1, -1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bc_operand_sequencer.md
# bc_operand_sequencer

Lane-0 consumer of the broadcast buffer's read port. Takes the 64-bit words popped from the active broadcast ping-pong half and splits each into two fp32 scalars. Delivers the scalars one per handshake to the lane's FPU scalar-operand port, repeating the broadcast vector for a configured number of passes. After the last pass, or on abort, it pulses the invalidate that frees the buffer half.

## Interface
Parameters:
- MaxBlen, 32, maximum broadcast vector length in fp32 elements; must be even and ≥2.
- MaxReps, 256, maximum pass count; RepsWidth = $clog2(MaxReps+1).

Ports:
- clk_i  in  1  clock; rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- cfg_valid_i  in  1  new broadcast job.
- cfg_ready_o  out  1  job accepted when high with cfg_valid_i.
- cfg_blen_i  in  $clog2(MaxBlen+1)  vector length in fp32 elements.
- cfg_reps_i  in  RepsWidth  number of passes over the vector.
- abort_i  in  1  synchronous kill of the current job.
- bc_data_i  in  64  word from broadcast buffer; element 2k in [31:0], element 2k+1 in [63:32].
- bc_valid_i  in  1  word available.
- bc_ready_o  out  1  pop request to the broadcast buffer.
- bc_invalidate_o  out  1  one-cycle pulse: flush current half, swap read side.
- scalar_o  out  32  fp32 operand.
- scalar_valid_o  out  1  operand valid.
- scalar_ready_i  in  1  FPU consumes operand.
- scalar_last_o  out  1  operand is the last element of a pass.
- scalar_final_o  out  1  operand is the last element of the last pass.
- busy_o  out  1  FSM not IDLE.

## Operation
- FSM states:
  - IDLE: cfg_ready_o=1. On cfg_valid_i, latch blen and reps, clear counters. If blen==0 or reps==0, go to INV; otherwise go to RUN.
  - RUN: stream scalars; exit to INV after the final element handshake or on abort_i.
  - INV: bc_invalidate_o=1 for exactly one cycle, then IDLE.
- Hold register: 64-bit data, valid bit, half pointer (0=lo, 1=hi).
  - scalar_o = half ? data[63:32] : data[31:0].
  - scalar_valid_o = hold valid in RUN.
- A word is loaded (bc_ready_o=1) in RUN when the hold register is empty, or when the current scalar handshakes and it is the last element taken from the word:
  - the hi half, or
  - the lo half when elem_cnt==blen-1 (odd blen: the hi half of the final word is discarded).
- Back-to-back: load and consume in the same cycle give one scalar per cycle, no bubble.
- Counters:
  - elem_cnt runs 0..blen-1 and wraps to 0 at pass end.
  - pass_cnt runs 0..reps-1.
  - scalar_last_o = (elem_cnt==blen-1).
  - scalar_final_o = scalar_last_o && (pass_cnt==reps-1).
- Pass wrap: the half pointer resets to 0. The next word popped is the buffer's replayed element 0; the upstream buffer re-presents the vector after its last word is popped.
- After the final handshake: clear the hold register, assert no further pop, go to INV.
- abort_i in RUN: drop the hold register and go to INV. abort_i in IDLE or INV is ignored. abort_i has priority over a same-cycle scalar handshake, which is not counted.
- Words needed per pass = ceil(blen/2). blen > MaxBlen is undefined and flagged by an assertion.

## Timing
- Reset values: cfg_ready_o=1; all other outputs 0; state IDLE, counters 0, hold empty.
- Config accepted at cycle t → RUN at t+1, bc_ready_o=1 at t+1.
- Word accepted at t → scalar_valid_o at t+1, with the lo half first.
- Steady state: 1 scalar/cycle; 1 pop per 2 scalars (per 1 scalar on the final odd element).
- Final handshake at t → bc_invalidate_o at t+1, cfg_ready_o at t+2.
- A zero-length job accepted at t → invalidate at t+1.
- scalar_o is stable while scalar_valid_o && !scalar_ready_i. bc_ready_o never depends combinationally on bc_valid_i.
- Reset mid-job: immediate return to reset values; no invalidate pulse.

## Test plan
- blen=4, reps=1, words {0x3F800000_00000000, 0x40400000_40000000}, ready always 1 → scalars 0x0,0x3F800000,0x40000000,0x40400000 on consecutive cycles; last on 4th; one invalidate one cycle after.
- blen=3, reps=2, buffer replays same 2 words → 6 scalars e0,e1,e2,e0,e1,e2; 4 pops total; upper half of word 2 never emitted; scalar_last_o on 3rd and 6th, final on 6th.
- Random scalar_ready_i stalls (50%), blen=32, reps=5 → 160 scalars in order, scalar_o stable during stalls, exactly 80 pops.
- abort_i asserted after 5th scalar with scalar_ready_i=1 in same cycle of blen=8, reps=2 → 5th not counted, invalidate next cycle, cfg_ready_o the cycle after, no further pops.
- cfg_blen_i=0 and, separately, cfg_reps_i=0 → no scalar_valid_o, no pop, single invalidate at t+1.
- rst_ni low mid-pass (async, between edges) → all outputs to reset values immediately; new job afterwards starts at element 0.
